regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32-entry SPARC register file between two writeback sources: port 0 (load data from memory) and port 1 (ALU/execute result). Each port has a one-entry holding register behind a valid/ready handshake. The arbiter grants one held entry per cycle and registers it onto the write port. That registered address drives a `decoder_5x32` to produce the one-hot write-select bus. Writes to %r0 (hardwired zero) are accepted and discarded.

## Interface
Parameters:
- `DATA_W`, default 32, register data width.
- `ADDR_W`, default 5, register address width; fixed at 5 to match the 5x32 decoder.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ld_valid` input 1: port 0 request valid.
- `ld_addr` input ADDR_W: port 0 destination register.
- `ld_data` input DATA_W: port 0 write data.
- `ld_ready` output 1: port 0 can accept this cycle.
- `alu_valid` input 1: port 1 request valid.
- `alu_addr` input ADDR_W: port 1 destination register.
- `alu_data` input DATA_W: port 1 write data.
- `alu_ready` output 1: port 1 can accept this cycle.
- `wr_enable` output 1: register-file write strobe, registered.
- `wr_addr` output ADDR_W: write address, registered.
- `wr_data` output DATA_W: write data, registered.
- `wr_select` output 32: one-hot row select. Equals 1<<wr_addr when wr_enable is 1, else 0.

## Operation
- **Acceptance:** each port accepts on a rising edge when valid && ready.
  - An accepted entry with addr==0 is dropped: held flag is not set, and no write ever occurs.
  - Otherwise the addr/data pair is captured into the port's holding register, and held is set.
- **Ready:** ready = !held || granted-this-cycle.
  - Grant depends only on held flags and the pointer, never on valid, so there is no combinational loop.
  - A granted port may refill in the same cycle, giving full throughput when uncontested.
- **Arbitration:** each cycle, among ports with held=1:
  - If one port is held, it is granted.
  - If both are held, the grant follows the policy in Configuration.
  - The granted entry's held flag clears, unless it is refilled in the same cycle.
- **Write register:** on each edge:
  - wr_enable <= any grant.
  - wr_addr/wr_data <= the granted entry, or hold their previous value when there is no grant.
- **Ordering:** writes to the same register issue in grant order; the later grant wins in the register file.
- **Reset values:** all held flags 0, so ld_ready=alu_ready=1. wr_enable=0, wr_addr=0, wr_data=0, wr_select=0, and the round-robin pointer prefers port 0.
- **Reset mid-operation:** held entries are discarded and are not written. An in-flight wr_enable drops immediately, because reset is asynchronous.

## Timing
- **Latency:** request sampled at edge N, held after N, granted during cycle N+1, and wr_enable/wr_addr/wr_data/wr_select valid from edge N+1 to edge N+2. That is 2 edges from acceptance to visible write.
- **Throughput:** 1 write per cycle total, shared between ports.
- **Contention:** while both ports stay busy, the losing port's ready is 0 for exactly 1 cycle per lost arbitration under round-robin. Under fixed priority it is unbounded.
- **wr_select:** combinational from the registered wr_enable/wr_addr; no extra cycle.

## Configuration
- Macro: `REGFILE_WR_RR_EN`.
- **Defined:** round-robin arbitration.
  - A 1-bit pointer names the preferred port and toggles only on a cycle where both ports were held and one was granted.
  - Worst-case wait is 1 cycle.
- **Undefined:** fixed priority, port 0 (load) always wins.
  - No pointer register exists.
  - Port 1 may starve under continuous loads.

## Structure
- **Shared package `regfile_pkg`:**
  - `REG_ADDR_W=5`, `REG_DATA_W=32`, `NUM_REGS=32`.
  - Port index constants `PORT_LD=0`, `PORT_ALU=1`.
  - `REG_ZERO=5'd0`.
  - A `wr_req_t` struct {addr, data}.
- **Sub-module:** one instance of the existing `decoder_5x32`, with in=wr_addr, enable=wr_enable, out=wr_select. All other logic is in this module.

## Test plan
- **Reset then idle:** assert reset mid-stream with both ports held -> wr_enable=0, wr_select=0, both readys=1; no writes after release.
- **Single load:** ld_valid with addr=7, data=0xDEADBEEF -> 2 edges later wr_enable=1, wr_addr=7, wr_select=0x00000080 for one cycle.
- **%r0 drop:** alu_valid with addr=0, data=0x12345678 -> alu_ready=1, and wr_enable stays 0 for 5 cycles.
- **Simultaneous, RR defined:** both ports continuously valid with distinct addrs -> writes alternate ld, alu, ld, alu, …, 1 per cycle, port 0 first after reset.
- **Simultaneous, RR undefined:** same stimulus -> only ld writes appear; alu_ready stays 0 until ld_valid drops, then alu writes the next cycle.
- **Same-address ordering:** ld and alu both write addr=3 (0x1111 and 0x2222) in the same cycle -> two writes in grant order; a register-file model ends with the later-granted value.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared register-file widths, port indices, zero-register address and write-request type.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic PORT_LD = 1'b0;
  localparam logic PORT_ALU = 1'b1;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: two writeback request ports (ld_*, alu_*) with valid/ready, plus registered write port (wr_*) and one-hot wr_select.
interface regfile_write_arbiter_if import regfile_pkg::*; #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);
  logic ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic ld_ready;
  logic alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic alu_ready;
  logic wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_REGS-1:0] wr_select;
  modport master (
    output ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
    input ld_ready, alu_ready, wr_enable, wr_addr, wr_data, wr_select
  );
  modport slave (
    input ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
    output ld_ready, alu_ready, wr_enable, wr_addr, wr_data, wr_select
  );
endinterface

// File: rtl/regfile_write_arbiter_decoder.sv
// decoder_5x32: one-hot row select; ports in[4:0], enable, out[31:0] (zero when enable is low).
module decoder_5x32 (
  input  logic [4:0]  in,
  input  logic        enable,
  output logic [31:0] out
);
  assign out = enable ? (32'd1 << in) : 32'd0;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates load/ALU writebacks onto one register-file write port; ports clk, reset (async high), bus (slave modport); REGFILE_WR_RR_EN selects round-robin, else fixed load priority.
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  logic r_ld_held, r_alu_held;
  logic [ADDR_W-1:0] r_ld_addr, r_alu_addr, r_wr_addr;
  logic [DATA_W-1:0] r_ld_data, r_alu_data, r_wr_data;
  logic r_wr_enable;
  logic w_gnt_ld, w_gnt_alu, w_acc_ld, w_acc_alu;
`ifdef REGFILE_WR_RR_EN
  logic r_ptr;
  assign w_gnt_ld = r_ld_held && (!r_alu_held || r_ptr == PORT_LD);
  // Pointer only moves when there was a real contest, so an idle port keeps its turn.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= PORT_LD;
    else if (r_ld_held && r_alu_held) r_ptr <= ~r_ptr;
`else
  assign w_gnt_ld = r_ld_held;
`endif
  assign w_gnt_alu = r_alu_held && !w_gnt_ld;
  // Grant uses only held state, so ready never depends on valid.
  assign bus.ld_ready = !r_ld_held || w_gnt_ld;
  assign bus.alu_ready = !r_alu_held || w_gnt_alu;
  assign w_acc_ld = bus.ld_valid && bus.ld_ready;
  assign w_acc_alu = bus.alu_valid && bus.alu_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_held <= 1'b0;
      r_alu_held <= 1'b0;
      r_ld_addr <= '0;
      r_ld_data <= '0;
      r_alu_addr <= '0;
      r_alu_data <= '0;
    end else begin
      if (w_acc_ld) begin
        r_ld_held <= bus.ld_addr != REG_ZERO;
        r_ld_addr <= bus.ld_addr;
        r_ld_data <= bus.ld_data;
      end else if (w_gnt_ld) r_ld_held <= 1'b0;
      if (w_acc_alu) begin
        r_alu_held <= bus.alu_addr != REG_ZERO;
        r_alu_addr <= bus.alu_addr;
        r_alu_data <= bus.alu_data;
      end else if (w_gnt_alu) r_alu_held <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_enable <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_enable <= w_gnt_ld || w_gnt_alu;
      if (w_gnt_ld) begin
        r_wr_addr <= r_ld_addr;
        r_wr_data <= r_ld_data;
      end else if (w_gnt_alu) begin
        r_wr_addr <= r_alu_addr;
        r_wr_data <= r_alu_data;
      end
    end
  end
  assign bus.wr_enable = r_wr_enable;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  decoder_5x32 u_dec (
    .in(r_wr_addr),
    .enable(r_wr_enable),
    .out(bus.wr_select)
  );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table, corner sequences and random stimulus against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
`ifdef REGFILE_WR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    bit ldv; logic [4:0] lda; logic [31:0] ldd;
    bit alv; logic [4:0] ala; logic [31:0] ald;
    bit e_ldr; bit e_alr; bit e_en; logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  regfile_write_arbiter_if bus ();
  regfile_write_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  wr_req_t q0[$];
  wr_req_t q1[$];
  int pref;
  bit m_en;
  wr_req_t m_w;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32];
  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ld;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
  endtask

  function automatic void m_reset();
    q0.delete(); q1.delete(); pref = 0; m_en = 1'b0; m_w = '0;
  endfunction

  // One clock cycle checked against the model; entered and left at a negedge.
  task automatic step();
    int g;
    bit rl, ra;
    #1;
    g = -1;
    if (q0.size() != 0 && q1.size() != 0) g = RR ? pref : 0;
    else if (q0.size() != 0) g = 0;
    else if (q1.size() != 0) g = 1;
    rl = q0.size() == 0 || g == 0;
    ra = q1.size() == 0 || g == 1;
    chk("ld_ready", bus.ld_ready, rl);
    chk("alu_ready", bus.alu_ready, ra);
    @(posedge clk);
    if (RR && q0.size() != 0 && q1.size() != 0) pref = 1 - pref;
    m_en = g >= 0;
    if (g == 0) m_w = q0.pop_front();
    else if (g == 1) m_w = q1.pop_front();
    if (m_en) m_rf[m_w.addr] = m_w.data;
    if (bus.ld_valid && rl && bus.ld_addr != 5'd0) q0.push_back('{addr: bus.ld_addr, data: bus.ld_data});
    if (bus.alu_valid && ra && bus.alu_addr != 5'd0) q1.push_back('{addr: bus.alu_addr, data: bus.alu_data});
    @(negedge clk);
    chk("wr_enable", bus.wr_enable, m_en);
    chk("wr_addr", bus.wr_addr, m_w.addr);
    chk("wr_data", bus.wr_data, m_w.data);
    chk("wr_select", bus.wr_select, m_en ? (32'd1 << m_w.addr) : 32'd0);
    if (bus.wr_enable) d_rf[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF};
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = vt[3];
    vt[7]  = '{1'b1, 5'd4, 32'hA4,       1'b1, 5'd5, 32'hA5,      1'b1, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 1'b1, 5'd4, 32'hA4};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b1, 5'd5, 32'hA5};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, 5'd5, 32'hA5};
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_wr_enable", bus.wr_enable, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_select", bus.wr_select, 0);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].ldv, vt[i].lda, vt[i].ldd, vt[i].alv, vt[i].ala, vt[i].ald);
      #1;
      chk($sformatf("vec%0d_ld_ready", i), bus.ld_ready, vt[i].e_ldr);
      chk($sformatf("vec%0d_alu_ready", i), bus.alu_ready, vt[i].e_alr);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_enable", i), bus.wr_enable, vt[i].e_en);
      chk($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_wr_data", i), bus.wr_data, vt[i].e_data);
      chk($sformatf("vec%0d_wr_select", i), bus.wr_select, vt[i].e_en ? (32'd1 << vt[i].e_addr) : 32'd0);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(8 + i), 32'h100 + i, 1, 5'(20 + i), 32'h200 + i);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 5'(20 + i), 32'h300 + i);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    do_reset();
    drive(1, 5'd3, 32'h1111, 1, 5'd3, 32'h2222);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("same_addr_last_wins", d_rf[3], 32'h2222);
    drive(1, 5'd9, 32'h909, 1, 5'd10, 32'hA0A);
    step();
    drive(1, 5'd11, 32'hB0B, 1, 5'd12, 32'hC0C);
    step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_wr_enable", bus.wr_enable, 0);
    chk("midrst_wr_select", bus.wr_select, 0);
    chk("midrst_ld_ready", bus.ld_ready, 1);
    chk("midrst_alu_ready", bus.alu_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    begin
      int bad;
      bad = 0;
      for (int r = 1; r < 32; r++) if (d_rf[r] !== m_rf[r]) bad++;
      chk("regfile_contents", bad, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
